// File: rtl/xlr_mem_arb_pkg.sv
// Shared types for the two-requester memory bank arbiter.
// Combinational types only: no latency, no flow control.
package xlr_mem_arb_pkg;

    localparam int NUM_REQ            = 2;
    localparam int XLR_DATA_W         = 32;
    localparam int XLR_LOG2_LINES     = 4;
    localparam int XLR_MAX_LOCK       = 8;

    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    typedef struct packed {
        logic                        wr;
        logic [XLR_LOG2_LINES-1:0]   addr;
        logic [XLR_DATA_W-1:0]       wdata;
        logic [XLR_DATA_W/8-1:0]     be;
    } xlr_mem_cmd_t;

endpackage

// File: rtl/xlr_mem_arb_if.sv
// Requester command/response bundle plus memory-bank port of the arbiter.
// Wires only: no latency; a requester is backpressured by req_gnt staying low.
interface xlr_mem_arb_if #(
    parameter int DATA_W             = 32,
    parameter int LOG2_LINES_PER_MEM = 4
);
    logic [1:0]                               req_valid;
    logic [1:0]                               req_wr;
    logic [1:0]                               req_lock;
    logic [1:0][LOG2_LINES_PER_MEM-1:0]       req_addr;
    logic [1:0][DATA_W-1:0]                   req_wdata;
    logic [1:0][DATA_W/8-1:0]                 req_be;
    logic [1:0]                               req_gnt;
    logic [1:0]                               rsp_valid;
    logic [DATA_W-1:0]                        rsp_rdata;
    logic [LOG2_LINES_PER_MEM-1:0]            xlr_mem_addr;
    logic [DATA_W-1:0]                        xlr_mem_wdata;
    logic [DATA_W/8-1:0]                      xlr_mem_be;
    logic                                     xlr_mem_rd;
    logic                                     xlr_mem_wr;
    logic [DATA_W-1:0]                        xlr_mem_rdata;
    logic                                     owner;

    modport slave (
        input  req_valid, req_wr, req_lock, req_addr, req_wdata, req_be, xlr_mem_rdata,
        output req_gnt, rsp_valid, rsp_rdata, xlr_mem_addr, xlr_mem_wdata, xlr_mem_be,
               xlr_mem_rd, xlr_mem_wr, owner
    );

    modport master (
        output req_valid, req_wr, req_lock, req_addr, req_wdata, req_be, xlr_mem_rdata,
        input  req_gnt, rsp_valid, rsp_rdata, xlr_mem_addr, xlr_mem_wdata, xlr_mem_be,
               xlr_mem_rd, xlr_mem_wr, owner
    );
endinterface

// File: rtl/xlr_mem_arb_rr_arb2.sv
// Two-way round-robin pick with lock and starvation guard; grant is combinational (0 cycles).
// A requester not granted simply holds its request; grant is forced to zero during reset.
module xlr_rr_arb2
    import xlr_mem_arb_pkg::*;
#(
    parameter int MAX_LOCK = XLR_MAX_LOCK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid_i,
    input  logic [1:0] req_lock_i,
    output logic [1:0] gnt_o,
    output req_idx_t   owner_o
);
    localparam int                CNT_W    = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_LOCK);

    req_idx_t           owner_q, owner_d, other, gnt_idx;
    logic               lock_q, lock_d, lock_act, gnt_any, relock;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

    always_comb begin
        other    = ~owner_q;
        lock_act = lock_q & req_valid_i[owner_q];
        gnt_any  = rst_n & (|req_valid_i);
        // Locked owner keeps the bank until the budget is spent and the other side is waiting.
        if (lock_act && ((lock_cnt_q < CNT_MAX) || !req_valid_i[other]))
            gnt_idx = owner_q;
        else if (&req_valid_i)
            gnt_idx = other;
        else
            gnt_idx = req_valid_i[1];
        gnt_o      = gnt_any ? (2'b01 << gnt_idx) : 2'b00;
        relock     = gnt_any & lock_act & (gnt_idx == owner_q);
        owner_d    = gnt_any ? gnt_idx : owner_q;
        lock_d     = gnt_any & req_lock_i[gnt_idx];
        lock_cnt_d = '0;
        if (relock)
            lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= 1'b1;
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign owner_o = owner_q;
endmodule

// File: rtl/xlr_mem_arb.sv
// Arbitrates two requesters onto one memory bank; command registered (1 cycle), read data returns in 2.
// Requesters see backpressure only as a missing req_gnt; responses cannot be stalled.
module xlr_mem_arb
    import xlr_mem_arb_pkg::*;
#(
    parameter int DATA_W             = XLR_DATA_W,
    parameter int LOG2_LINES_PER_MEM = XLR_LOG2_LINES,
    parameter int MAX_LOCK           = XLR_MAX_LOCK
) (
    input  logic          clk,
    input  logic          rst_n,
    xlr_mem_arb_if.slave  bus
);
    logic [1:0]     gnt;
    req_idx_t       owner, gidx;
    xlr_mem_cmd_t   cmd_q, cmd_d;
    logic           cmd_vld_q;
    logic [1:0]     rsp_s1_q, rsp_s2_q;

    xlr_rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (bus.req_valid),
        .req_lock_i  (bus.req_lock),
        .gnt_o       (gnt),
        .owner_o     (owner)
    );

    assign gidx = gnt[1];

    always_comb begin
        cmd_d = cmd_q;
        if (|gnt) begin
            cmd_d.wr    = bus.req_wr[gidx];
            cmd_d.addr  = bus.req_addr[gidx];
            cmd_d.wdata = bus.req_wdata[gidx];
            cmd_d.be    = bus.req_be[gidx];
        end
    end

    // Read tags travel two stages so rsp_valid lines up with xlr_mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            cmd_vld_q <= 1'b0;
            rsp_s1_q  <= '0;
            rsp_s2_q  <= '0;
        end else begin
            cmd_q     <= cmd_d;
            cmd_vld_q <= |gnt;
            rsp_s1_q  <= gnt & ~bus.req_wr;
            rsp_s2_q  <= rsp_s1_q;
        end
    end

    assign bus.req_gnt       = gnt;
    assign bus.owner         = owner;
    assign bus.xlr_mem_addr  = cmd_q.addr;
    assign bus.xlr_mem_wdata = cmd_q.wdata;
    assign bus.xlr_mem_be    = cmd_q.be;
    assign bus.xlr_mem_wr    = cmd_vld_q & cmd_q.wr;
    assign bus.xlr_mem_rd    = cmd_vld_q & ~cmd_q.wr;
    assign bus.rsp_valid     = rsp_s2_q;
    assign bus.rsp_rdata     = bus.xlr_mem_rdata;
endmodule

// File: tb/tb_xlr_mem_arb.sv
// Directed bench for xlr_mem_arb: behavioural memory bank plus per-scenario tasks.
module tb_xlr_mem_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    logic [31:0] mem [16];

    xlr_mem_arb_if mif ();

    xlr_mem_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    // Bank model: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mif.xlr_mem_wr)
            for (int b = 0; b < 4; b++)
                if (mif.xlr_mem_be[b]) mem[mif.xlr_mem_addr][b*8 +: 8] <= mif.xlr_mem_wdata[b*8 +: 8];
        if (mif.xlr_mem_rd)
            mif.xlr_mem_rdata <= mem[mif.xlr_mem_addr];
    end

    task automatic drive_idle(int n);
        repeat (n) begin
            @(negedge clk);
            mif.req_valid = 2'b00;
            mif.req_lock  = 2'b00;
            mif.req_wr    = 2'b00;
        end
    endtask

    task automatic test_reset();
        mif.req_valid = 2'b11;
        #3;
        chk_cnt++; if (mif.req_gnt !== 2'b00) $display("FAIL rst_gnt_masked got=%b exp=00", mif.req_gnt); else pass_cnt++;
        mif.req_valid = 2'b00;
        #17 rst_n = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk_cnt++; if (mif.req_gnt !== 2'b00) $display("FAIL rst_gnt got=%b exp=00", mif.req_gnt); else pass_cnt++;
        chk_cnt++; if ({mif.xlr_mem_rd, mif.xlr_mem_wr} !== 2'b00) $display("FAIL rst_strobes got=%b exp=00", {mif.xlr_mem_rd, mif.xlr_mem_wr}); else pass_cnt++;
        chk_cnt++; if (mif.rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got=%b exp=00", mif.rsp_valid); else pass_cnt++;
        chk_cnt++; if (mif.owner !== 1'b1) $display("FAIL rst_owner got=%b exp=1", mif.owner); else pass_cnt++;
        chk_cnt++; if ({mif.xlr_mem_addr, mif.xlr_mem_wdata, mif.xlr_mem_be} !== 40'h0) $display("FAIL rst_cmd got=%h exp=0", {mif.xlr_mem_addr, mif.xlr_mem_wdata, mif.xlr_mem_be}); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g, exp_r;
        logic [31:0] exp_d;
        int j;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            mif.req_valid   = (k < 6) ? 2'b11 : 2'b00;
            mif.req_wr      = 2'b00;
            mif.req_lock    = 2'b00;
            mif.req_addr[0] = 4'(k);
            mif.req_addr[1] = 4'(k + 8);
            #1;
            exp_g = (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            chk_cnt++; if (mif.req_gnt !== exp_g) $display("FAIL cont_gnt[%0d] got=%b exp=%b", k, mif.req_gnt, exp_g); else pass_cnt++;
            j = k - 2;
            exp_r = (j < 0 || j >= 6) ? 2'b00 : ((j % 2 == 0) ? 2'b01 : 2'b10);
            chk_cnt++; if (mif.rsp_valid !== exp_r) $display("FAIL cont_rsp_valid[%0d] got=%b exp=%b", k, mif.rsp_valid, exp_r); else pass_cnt++;
            if (exp_r != 2'b00) begin
                exp_d = 32'h1000_0000 + 32'((j % 2 == 0) ? j : j + 8);
                chk_cnt++; if (mif.rsp_rdata !== exp_d) $display("FAIL cont_rdata[%0d] got=%h exp=%h", k, mif.rsp_rdata, exp_d); else pass_cnt++;
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        mif.req_valid = 2'b01; mif.req_wr = 2'b01; mif.req_lock = 2'b00;
        mif.req_addr[0] = 4'd3; mif.req_wdata[0] = 32'hA5A5_0001; mif.req_be[0] = 4'hF;
        #1;
        chk_cnt++; if (mif.req_gnt !== 2'b01) $display("FAIL wr_gnt got=%b exp=01", mif.req_gnt); else pass_cnt++;
        @(negedge clk);
        mif.req_valid = 2'b01; mif.req_wr = 2'b00; mif.req_addr[0] = 4'd3;
        #1;
        chk_cnt++; if ({mif.xlr_mem_wr, mif.xlr_mem_rd} !== 2'b10) $display("FAIL wr_strobe got=%b exp=10", {mif.xlr_mem_wr, mif.xlr_mem_rd}); else pass_cnt++;
        chk_cnt++; if ({mif.xlr_mem_addr, mif.xlr_mem_wdata, mif.xlr_mem_be} !== {4'd3, 32'hA5A5_0001, 4'hF}) $display("FAIL wr_cmd got=%h exp=%h", {mif.xlr_mem_addr, mif.xlr_mem_wdata, mif.xlr_mem_be}, {4'd3, 32'hA5A5_0001, 4'hF}); else pass_cnt++;
        @(negedge clk);
        mif.req_valid = 2'b00;
        #1;
        chk_cnt++; if ({mif.xlr_mem_wr, mif.xlr_mem_rd} !== 2'b01) $display("FAIL rd_strobe got=%b exp=01", {mif.xlr_mem_wr, mif.xlr_mem_rd}); else pass_cnt++;
        chk_cnt++; if (mif.rsp_valid !== 2'b00) $display("FAIL wr_no_rsp got=%b exp=00", mif.rsp_valid); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (mif.rsp_valid !== 2'b01) $display("FAIL rd_rsp_valid got=%b exp=01", mif.rsp_valid); else pass_cnt++;
        chk_cnt++; if (mif.rsp_rdata !== 32'hA5A5_0001) $display("FAIL rd_rdata got=%h exp=a5a50001", mif.rsp_rdata); else pass_cnt++;
        chk_cnt++; if ({mif.xlr_mem_wr, mif.xlr_mem_rd, mif.xlr_mem_addr} !== {2'b00, 4'd3}) $display("FAIL idle_hold got=%h exp=03", {mif.xlr_mem_wr, mif.xlr_mem_rd, mif.xlr_mem_addr}); else pass_cnt++;
    endtask

    task automatic test_lock_starve();
        logic [1:0] exp_g;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            mif.req_valid = 2'b11; mif.req_wr = 2'b00; mif.req_lock = 2'b10;
            #1;
            exp_g = (k == 9) ? 2'b01 : 2'b10;
            chk_cnt++; if (mif.req_gnt !== exp_g) $display("FAIL lock_gnt[%0d] got=%b exp=%b", k, mif.req_gnt, exp_g); else pass_cnt++;
            if (k == 10) begin
                chk_cnt++; if (mif.owner !== 1'b0) $display("FAIL lock_owner got=%b exp=0", mif.owner); else pass_cnt++;
            end
        end
        drive_idle(3);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        mif.req_valid = 2'b01; mif.req_wr = 2'b00; mif.req_lock = 2'b00; mif.req_addr[0] = 4'd3;
        #1;
        chk_cnt++; if (mif.req_gnt !== 2'b01) $display("FAIL mid_gnt got=%b exp=01", mif.req_gnt); else pass_cnt++;
        @(negedge clk);
        mif.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({mif.xlr_mem_rd, mif.owner} !== 2'b01) $display("FAIL mid_rst_state got=%b exp=01", {mif.xlr_mem_rd, mif.owner}); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            #1;
            chk_cnt++; if (mif.rsp_valid !== 2'b00) $display("FAIL mid_rsp_valid[%0d] got=%b exp=00", k, mif.rsp_valid); else pass_cnt++;
        end
        @(negedge clk);
        mif.req_valid = 2'b11;
        #1;
        chk_cnt++; if (mif.req_gnt !== 2'b01) $display("FAIL mid_first_contention got=%b exp=01", mif.req_gnt); else pass_cnt++;
        drive_idle(2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mif.req_valid = 2'b00; mif.req_wr = 2'b00; mif.req_lock = 2'b00;
        mif.req_addr = '0; mif.req_wdata = '0; mif.req_be = '0;
        mif.xlr_mem_rdata = '0;
        test_reset();
        test_contention();
        test_write_read();
        test_lock_starve();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
